chacha20_block_core: RTL and testbench
======================================

CHACHA20_BLOCK_CORE -- requirements
Module: chacha20_block_core

Interface
REQ-001 Parameter PIPELINE_STAGES, default `CHACHA20_PIPELINE_STAGES, passed unchanged to every quarter_round instance.
REQ-002 Parameter DOUBLE_ROUNDS, default 10, is the number of column+diagonal round pairs.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  key/nonce/counter valid.
REQ-006 in_ready  output  1  core idle and able to accept a job.
REQ-007 key  input  256  key; state word 4+i = key[32*i+:32], i=0..7.
REQ-008 nonce  input  96  nonce; word 13+j = nonce[32*j+:32], j=0..2.
REQ-009 counter  input  32  block counter; word 12.
REQ-010 out_valid  output  1  keystream holds a finished block.
REQ-011 out_ready  input  1  consumer takes the block.
REQ-012 keystream  output  512  block; word i = keystream[32*i+:32], i=0..15.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states SHALL be IDLE, ROUND, FINAL, DONE; in_ready = (state==IDLE).
REQ-015 IDLE: on in_valid&&in_ready the 16-word state and a copy (init) SHALL load words 0-3 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574 plus key/counter/nonce, then ->ROUND.
REQ-016 ROUND SHALL drive four quarter_round instances from the state register; even half-rounds use columns (0,4,8,12)(1,5,9,13)(2,6,10,14)(3,7,11,15), odd use diagonals (0,5,10,15)(1,6,11,12)(2,7,8,13)(3,4,9,14).
REQ-017 Each half-round SHALL take H cycles: H=1 if PIPELINE_STAGES==0, else H=3 (two quarter_round register stages plus capture); a wait counter holds the state stable until capture.
REQ-018 A half-round counter SHALL count 0..2*DOUBLE_ROUNDS-1; after capturing the last half-round the FSM SHALL go to FINAL.
REQ-019 FINAL: on the next edge keystream word i <= state[i]+init[i] mod 2^32, out_valid <= 1, ->DONE.
REQ-020 Latency from the accepting edge to out_valid rising SHALL be 2*DOUBLE_ROUNDS*H+1 cycles (21 for H=1, 61 for H=3 at default).
REQ-021 DONE: keystream and out_valid SHALL hold until out_valid&&out_ready; at that edge out_valid <= 0 and ->IDLE.
REQ-022 in_valid while in_ready=0 SHALL be ignored with no effect on the running job.
REQ-023 out_ready is ignored while out_valid=0; out_ready already high when out_valid rises completes the handshake on the first DONE edge.
REQ-024 The counter SHALL NOT auto-increment; counter=0xFFFFFFFF is processed like any other value.
REQ-025 All additions SHALL wrap mod 2^32, with no carry into adjacent words.

Reset
REQ-026 rst_n low SHALL force IDLE, out_valid=0, busy=0, in_ready=1 after release, and keystream, state, init and all counters to 0.
REQ-027 Reset mid-job SHALL abort it with no output; the next accepted job runs from scratch.

Structure
REQ-028 The sigma constants, the state-word index map and the FSM state encoding SHALL live in the shared chacha20 defines header with `CHACHA20_PIPELINE_STAGES.
REQ-029 The sole sub-module SHALL be the existing quarter_round, instantiated four times; column/diagonal muxing and the final add stay in this module.

Verification
REQ-030 RFC 8439 §2.3.2 (key 0x00..0x1f, i.e. word4=0x03020100 ... word11=0x1f1e1d1c; counter=1; nonce words 0x09000000, 0x4a000000, 0x00000000) -> word0=0xe4e7f110, word1=0x15593bd1, word15=0x4e3c50a2; all 16 words match the RFC.
REQ-031 The REQ-030 vector run at PIPELINE_STAGES=0, 1 and 2 -> identical keystream; out_valid rises exactly 21, 61 and 61 cycles after acceptance.
REQ-032 Hold out_ready=0 for 10 cycles after out_valid -> keystream stable and in_ready=0 throughout; a second in_valid pulse during the stall is ignored.
REQ-033 Two jobs back-to-back with out_ready tied high, counters 0xFFFFFFFF then 0x00000000 -> two distinct blocks, each equal to the reference model, with no auto-increment.
REQ-034 Assert rst_n low at cycle 7 of a job -> out_valid stays 0, all outputs are 0; a fresh REQ-030 job after release gives the correct result.

Source files
------------

// File: rtl/chacha20_pkg.sv
// Shared ChaCha20 definitions: sigma constants, state-word map, FSM states,
// default pipelining and the quarter-round index/rotate helpers.
package chacha20_pkg;

   localparam int CHACHA20_PIPELINE_STAGES = 2;

   // "expand 32-byte k", word 0 in the low slot
   localparam logic [3:0][31:0] SIGMA = {32'h6b206574, 32'h79622d32,
                                         32'h3320646e, 32'h61707865};

   localparam int unsigned W_KEY   = 4;
   localparam int unsigned W_CNT   = 12;
   localparam int unsigned W_NONCE = 13;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ROUND,
      ST_FINAL,
      ST_DONE
   } state_e;

   // Word k of quarter-round q; diagonals shift each row by its row number.
   function automatic logic [3:0] qr_idx(input logic diag, input logic [1:0] q,
                                         input logic [1:0] k);
      logic [1:0] col;
      col = q + (diag ? k : 2'd0);
      return {k, col};
   endfunction

   function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
      return (x << n) | (x >> (32 - n));
   endfunction

endpackage

// File: rtl/chacha20_quarter_round.sv
// ChaCha20 quarter round; combinational, or two register stages (one per
// half of the add-xor-rotate chain) when PIPELINE_STAGES is non-zero.
module quarter_round
   import chacha20_pkg::*;
#(
   parameter int PIPELINE_STAGES = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic [31:0] i_c,
   input  logic [31:0] i_d,
   output logic [31:0] o_a,
   output logic [31:0] o_b,
   output logic [31:0] o_c,
   output logic [31:0] o_d
);

   logic [31:0] w_a1, w_b1, w_c1, w_d1;
   logic [31:0] w_a2, w_b2, w_c2, w_d2;
   logic [31:0] w_a3, w_b3, w_c3, w_d3;

   always_comb begin
      w_a1 = i_a + i_b;
      w_d1 = rotl(i_d ^ w_a1, 16);
      w_c1 = i_c + w_d1;
      w_b1 = rotl(i_b ^ w_c1, 12);
      w_a3 = w_a2 + w_b2;
      w_d3 = rotl(w_d2 ^ w_a3, 8);
      w_c3 = w_c2 + w_d3;
      w_b3 = rotl(w_b2 ^ w_c3, 7);
   end

   generate
      if (PIPELINE_STAGES == 0) begin : g_comb
         assign {w_a2, w_b2, w_c2, w_d2} = {w_a1, w_b1, w_c1, w_d1};
         assign {o_a, o_b, o_c, o_d}     = {w_a3, w_b3, w_c3, w_d3};
      end else begin : g_pipe
         logic [31:0] r_a1, r_b1, r_c1, r_d1;
         logic [31:0] r_a2, r_b2, r_c2, r_d2;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               {r_a1, r_b1, r_c1, r_d1} <= '0;
               {r_a2, r_b2, r_c2, r_d2} <= '0;
            end else begin
               {r_a1, r_b1, r_c1, r_d1} <= {w_a1, w_b1, w_c1, w_d1};
               {r_a2, r_b2, r_c2, r_d2} <= {w_a3, w_b3, w_c3, w_d3};
            end
         end

         assign {w_a2, w_b2, w_c2, w_d2} = {r_a1, r_b1, r_c1, r_d1};
         assign {o_a, o_b, o_c, o_d}     = {r_a2, r_b2, r_c2, r_d2};
      end
   endgenerate

endmodule

// File: rtl/chacha20_block_core.sv
// ChaCha20 block function: loads sigma/key/counter/nonce, runs 2*DOUBLE_ROUNDS
// half-rounds through four quarter_round instances, then adds the input state.
module chacha20_block_core
   import chacha20_pkg::*;
#(
   parameter int PIPELINE_STAGES = CHACHA20_PIPELINE_STAGES,
   parameter int DOUBLE_ROUNDS   = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [255:0] key,
   input  logic [95:0]  nonce,
   input  logic [31:0]  counter,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [511:0] keystream,
   output logic         busy
);

   localparam int unsigned H     = (PIPELINE_STAGES == 0) ? 1 : 3;
   localparam int unsigned NHALF = 2 * DOUBLE_ROUNDS;
   localparam int unsigned HW    = (NHALF > 1) ? $clog2(NHALF) : 1;
   localparam logic [HW-1:0] LAST_HALF = HW'(NHALF - 1);
   localparam logic [1:0]    LAST_WAIT = 2'(H - 1);

   state_e             r_fsm;
   logic [15:0][31:0]  r_state;
   logic [15:0][31:0]  r_init;
   logic [15:0][31:0]  r_ks;
   logic               r_out_valid;
   logic [HW-1:0]      r_half;
   logic [1:0]         r_wait;

   logic [15:0][31:0]  w_load;
   logic [15:0][31:0]  w_next;
   logic [3:0][31:0]   w_qa, w_qb, w_qc, w_qd;
   logic [3:0][31:0]   w_ra, w_rb, w_rc, w_rd;

   always_comb begin
      w_load = '0;
      for (int unsigned i = 0; i < 4; i++) w_load[i] = SIGMA[i];
      for (int unsigned i = 0; i < 8; i++) w_load[W_KEY + i] = key[32*i +: 32];
      w_load[W_CNT] = counter;
      for (int unsigned j = 0; j < 3; j++) w_load[W_NONCE + j] = nonce[32*j +: 32];
   end

   // Even half-rounds select columns, odd select diagonals
   always_comb begin
      w_qa = '0;
      w_qb = '0;
      w_qc = '0;
      w_qd = '0;
      for (int unsigned q = 0; q < 4; q++) begin
         w_qa[q] = r_state[qr_idx(r_half[0], 2'(q), 2'd0)];
         w_qb[q] = r_state[qr_idx(r_half[0], 2'(q), 2'd1)];
         w_qc[q] = r_state[qr_idx(r_half[0], 2'(q), 2'd2)];
         w_qd[q] = r_state[qr_idx(r_half[0], 2'(q), 2'd3)];
      end
   end

   always_comb begin
      w_next = r_state;
      for (int unsigned q = 0; q < 4; q++) begin
         w_next[qr_idx(r_half[0], 2'(q), 2'd0)] = w_ra[q];
         w_next[qr_idx(r_half[0], 2'(q), 2'd1)] = w_rb[q];
         w_next[qr_idx(r_half[0], 2'(q), 2'd2)] = w_rc[q];
         w_next[qr_idx(r_half[0], 2'(q), 2'd3)] = w_rd[q];
      end
   end

   generate
      for (genvar g = 0; g < 4; g++) begin : g_qr
         quarter_round #(
            .PIPELINE_STAGES(PIPELINE_STAGES)
         ) u_qr (
            .clk   (clk),
            .rst_n (rst_n),
            .i_a   (w_qa[g]),
            .i_b   (w_qb[g]),
            .i_c   (w_qc[g]),
            .i_d   (w_qd[g]),
            .o_a   (w_ra[g]),
            .o_b   (w_rb[g]),
            .o_c   (w_rc[g]),
            .o_d   (w_rd[g])
         );
      end
   endgenerate

   // The state is held while pipelined quarter rounds settle; r_wait marks capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsm       <= ST_IDLE;
         r_state     <= '0;
         r_init      <= '0;
         r_ks        <= '0;
         r_out_valid <= 1'b0;
         r_half      <= '0;
         r_wait      <= '0;
      end else begin
         case (r_fsm)
            ST_IDLE: begin
               if (in_valid) begin
                  r_state <= w_load;
                  r_init  <= w_load;
                  r_half  <= '0;
                  r_wait  <= '0;
                  r_fsm   <= ST_ROUND;
               end
            end
            ST_ROUND: begin
               if (r_wait == LAST_WAIT) begin
                  r_wait  <= '0;
                  r_state <= w_next;
                  if (r_half == LAST_HALF) begin
                     r_half <= '0;
                     r_fsm  <= ST_FINAL;
                  end else begin
                     r_half <= r_half + 1'b1;
                  end
               end else begin
                  r_wait <= r_wait + 1'b1;
               end
            end
            ST_FINAL: begin
               for (int unsigned i = 0; i < 16; i++) r_ks[i] <= r_state[i] + r_init[i];
               r_out_valid <= 1'b1;
               r_fsm       <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_fsm       <= ST_IDLE;
               end
            end
            default: r_fsm <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_fsm == ST_IDLE);
   assign busy      = (r_fsm != ST_IDLE);
   assign out_valid = r_out_valid;
   assign keystream = r_ks;

endmodule

// File: tb/tb_chacha20_block_core.sv
// Self-checking bench for chacha20_block_core against an RFC 8439 block model.
module tb_chacha20_block_core;

   localparam int DR   = 10;
   localparam int LAT  = 2 * DR * 3 + 1;
   localparam int LAT0 = 2 * DR * 1 + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         out_ready = 1'b0;
   logic [255:0] key       = '0;
   logic [95:0]  nonce     = '0;
   logic [31:0]  counter   = '0;
   logic         in_ready, out_valid, busy;
   logic [511:0] keystream;

   logic         x_in_valid  = 1'b0;
   logic         x_out_ready = 1'b0;
   logic         x0_in_ready, x0_out_valid, x0_busy;
   logic         x1_in_ready, x1_out_valid, x1_busy;
   logic [511:0] x0_ks, x1_ks;

   chacha20_block_core #(.DOUBLE_ROUNDS(DR)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .key(key), .nonce(nonce), .counter(counter), .out_valid(out_valid),
      .out_ready(out_ready), .keystream(keystream), .busy(busy));

   chacha20_block_core #(.PIPELINE_STAGES(0), .DOUBLE_ROUNDS(DR)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(x0_in_ready),
      .key(key), .nonce(nonce), .counter(counter), .out_valid(x0_out_valid),
      .out_ready(x_out_ready), .keystream(x0_ks), .busy(x0_busy));

   chacha20_block_core #(.PIPELINE_STAGES(1), .DOUBLE_ROUNDS(DR)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(x1_in_ready),
      .key(key), .nonce(nonce), .counter(counter), .out_valid(x1_out_valid),
      .out_ready(x_out_ready), .keystream(x1_ks), .busy(x1_busy));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference block function written straight from RFC 8439
   function automatic logic [31:0] rl(input logic [31:0] x, input int n);
      return (x << n) | (x >> (32 - n));
   endfunction

   function automatic logic [15:0][31:0] mqr(input logic [15:0][31:0] s,
                                             input int a, input int b, input int c, input int d);
      logic [15:0][31:0] x;
      x = s;
      x[a] = x[a] + x[b]; x[d] = rl(x[d] ^ x[a], 16);
      x[c] = x[c] + x[d]; x[b] = rl(x[b] ^ x[c], 12);
      x[a] = x[a] + x[b]; x[d] = rl(x[d] ^ x[a], 8);
      x[c] = x[c] + x[d]; x[b] = rl(x[b] ^ x[c], 7);
      return x;
   endfunction

   function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [95:0] n,
                                              input logic [31:0] c);
      logic [15:0][31:0] s, x;
      s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
      for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
      s[12] = c;
      for (int j = 0; j < 3; j++) s[13+j] = n[32*j +: 32];
      x = s;
      for (int r = 0; r < DR; r++) begin
         x = mqr(x, 0, 4, 8, 12); x = mqr(x, 1, 5, 9, 13);
         x = mqr(x, 2, 6, 10, 14); x = mqr(x, 3, 7, 11, 15);
         x = mqr(x, 0, 5, 10, 15); x = mqr(x, 1, 6, 11, 12);
         x = mqr(x, 2, 7, 8, 13);  x = mqr(x, 3, 4, 9, 14);
      end
      for (int i = 0; i < 16; i++) x[i] = x[i] + s[i];
      return x;
   endfunction

   // Protocol model: idle -> busy for LAT edges -> valid until out_ready
   logic         m_idle  = 1'b1;
   logic         m_valid = 1'b0;
   int           m_cnt   = 0;
   logic [511:0] m_ks    = '0;
   logic [511:0] m_pend  = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_idle <= 1'b1; m_valid <= 1'b0; m_cnt <= 0; m_ks <= '0;
      end else if (m_idle) begin
         if (in_valid) begin
            m_idle <= 1'b0; m_cnt <= LAT; m_pend <= ref_block(key, nonce, counter);
         end
      end else if (m_valid) begin
         if (out_ready) begin m_valid <= 1'b0; m_idle <= 1'b1; end
      end else begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin m_valid <= 1'b1; m_ks <= m_pend; end
      end
   end

   always @(negedge clk) begin
      chk("in_ready", in_ready, m_idle);
      chk("busy", busy, !m_idle);
      chk("out_valid", out_valid, m_valid);
      if (m_valid) chk("keystream", keystream, m_ks);
   end

   task automatic run_job(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                          output int lat);
      int w;
      w = 0;
      while (!in_ready && w < 300) begin @(negedge clk); w++; end
      chk("accept_bound", (w < 300), 1'b1);
      key = k; nonce = n; counter = c; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 300) begin @(negedge clk); lat++; end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [31:0]  rfc_w [16];
   logic [511:0] rfc_exp, held, b1, b2;
   logic [255:0] rfc_key, rk;
   logic [95:0]  rfc_nonce, rn;
   int           lat, lat0, lat1, t;
   logic         seen;

   initial begin
      rfc_w = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
                32'hc7f4d1c7, 32'h0368c033, 32'h9aaa2204, 32'h4e6cd4c3,
                32'h466482d2, 32'h09aa9f07, 32'h05d7c214, 32'ha2028bd9,
                32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};
      for (int i = 0; i < 16; i++) rfc_exp[32*i +: 32] = rfc_w[i];
      for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = 8'(i);
      rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};

      repeat (3) @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_keystream", keystream, '0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b1);

      chk("model_rfc", ref_block(rfc_key, rfc_nonce, 32'd1), rfc_exp);

      run_job(rfc_key, rfc_nonce, 32'd1, lat);
      chk("rfc_latency", lat, LAT);
      chk("rfc_block", keystream, rfc_exp);
      chk("rfc_word0", keystream[31:0], 32'he4e7f110);
      chk("rfc_word15", keystream[511:480], 32'h4e3c50a2);
      drain();

      // Unpipelined and single-stage builds
      x_in_valid = 1'b1;
      @(negedge clk);
      x_in_valid = 1'b0;
      t = 0; lat0 = -1; lat1 = -1;
      while ((lat0 < 0 || lat1 < 0) && t < 300) begin
         @(negedge clk); t++;
         if (x0_out_valid && lat0 < 0) lat0 = t;
         if (x1_out_valid && lat1 < 0) lat1 = t;
      end
      chk("ps0_latency", lat0, LAT0);
      chk("ps1_latency", lat1, LAT);
      chk("ps0_block", x0_ks, rfc_exp);
      chk("ps1_block", x1_ks, rfc_exp);
      x_out_ready = 1'b1;
      @(negedge clk);
      x_out_ready = 1'b0;

      // Output stall with an ignored second request
      run_job(rfc_key, rfc_nonce, 32'h12345678, lat);
      held = keystream;
      for (int i = 0; i < 10; i++) begin
         in_valid = (i == 4);
         if (i == 4) counter = 32'hdeadbeef;
         @(negedge clk);
         chk("stall_keystream", keystream, held);
         chk("stall_in_ready", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      chk("stall_block", held, ref_block(rfc_key, rfc_nonce, 32'h12345678));
      drain();

      // Back-to-back, out_ready tied high, counter wrap value then zero
      out_ready = 1'b1;
      run_job(rfc_key, rfc_nonce, 32'hffffffff, lat);
      b1 = keystream;
      chk("b2b_lat1", lat, LAT);
      chk("b2b_block1", b1, ref_block(rfc_key, rfc_nonce, 32'hffffffff));
      run_job(rfc_key, rfc_nonce, 32'h00000000, lat);
      b2 = keystream;
      chk("b2b_lat2", lat, LAT);
      chk("b2b_block2", b2, ref_block(rfc_key, rfc_nonce, 32'h00000000));
      chk("b2b_distinct", (b1 != b2), 1'b1);
      @(negedge clk);
      out_ready = 1'b0;

      // Reset in the middle of a job
      key = rfc_key; nonce = rfc_nonce; counter = 32'd1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_keystream", keystream, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (70) begin @(negedge clk); seen = seen | out_valid; end
      chk("midrst_no_output", seen, 1'b0);
      run_job(rfc_key, rfc_nonce, 32'd1, lat);
      chk("postrst_latency", lat, LAT);
      chk("postrst_block", keystream, rfc_exp);
      drain();

      // Random jobs with random consumer delay
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 8; i++) rk[32*i +: 32] = $urandom;
         for (int j = 0; j < 3; j++) rn[32*j +: 32] = $urandom;
         counter = $urandom;
         run_job(rk, rn, counter, lat);
         chk("rand_latency", lat, LAT);
         chk("rand_block", keystream, ref_block(rk, rn, counter));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         drain();
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
